regfile_np: RTL and testbench
=============================

Name: regfile_np

Overview:
- Parametrised register file: DEPTH registers of WIDTH bits each.
- One synchronous write port and two independent combinational read ports; each read port is a generalised N-way mux.
- A built-in clear sequencer resets the whole array on request, one register per cycle, and reports busy/done.
- Replaces the fixed 8x8 register file and its mux8 read path in the datapath.

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 8, number of registers; must be >= 2; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived, not to be overridden.
- RESET_VAL, 0, value loaded into every register by reset and by the clear sequence.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  ADDR_W  read port A address.
- raddr_b  in  ADDR_W  read port B address.
- dout_a  out  WIDTH  read port A data.
- dout_b  out  WIDTH  read port B data.
- clr_req  in  1  request a full-array clear; sampled in IDLE only.
- busy  out  1  high while the clear sequence runs.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset:
  - All registers go to RESET_VAL; FSM goes to IDLE; clear pointer goes to 0.
  - busy=0, clr_done=0.
  - dout_a/dout_b therefore read RESET_VAL.
- Write:
  - At a rising clk edge with we=1, busy=0 and waddr<DEPTH: regs[waddr] <= wdata.
  - Write latency is 1 cycle.
  - Writes with waddr>=DEPTH are silently dropped.
- Read:
  - dout_x = regs[raddr_x] combinationally, with zero latency.
  - raddr_x>=DEPTH returns 0.
  - Both ports may address the same register.
- FSM states are IDLE, CLEAR and DONE.
  - IDLE: clr_req=1 -> CLEAR, with ptr=0.
  - CLEAR:
    - busy=1; regs[ptr] <= RESET_VAL each cycle; ptr increments.
    - When ptr==DEPTH-1 is written -> DONE.
    - The sequence takes exactly DEPTH cycles.
  - DONE: clr_done=1 for one cycle, busy=0 -> IDLE.
- busy and clr_done are registered outputs.
- Writes while busy=1 are dropped, not queued.
- clr_req during CLEAR or DONE is ignored; no restart occurs.
- we=1 and clr_req=1 at the same IDLE edge: the write commits, then the clear starts and overwrites it.
- Reads during CLEAR return the current contents: already-cleared entries read RESET_VAL, the rest read old data.
- rst asserted mid-clear aborts immediately to the reset state; no clr_done pulse is produced.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if we=1, busy=0, waddr<DEPTH and waddr==raddr_x, then dout_x=wdata in the same cycle.
  - This applies per port.
- Undefined: dout_x shows the old value until the edge after the write.

Decomposition:
- Package regfile_pkg holds:
  - The FSM state enum (IDLE, CLEAR, DONE).
  - A helper function for out-of-range address checking.
- Sub-module mux_n(WIDTH, DEPTH) is the parametrised successor of mux8.
  - Input is a flat DEPTH*WIDTH bus; output returns 0 for an out-of-range select.
  - It is instantiated once per read port.

Test Plan:
- Reset then read: after rst with RESET_VAL=0, read all 8 addresses on both ports -> every read returns 8'h00; busy=0, clr_done=0.
- Write then dual read: write 1..8 to addresses 0..7; then sweep raddr_a 0..7 while raddr_b=7-raddr_a -> dout_a=addr+1, dout_b=8-addr.
- Same-cycle write/read: we=1, waddr=3, wdata=8'hA5, raddr_a=3.
  - Without bypass: dout_a shows the old value 8'h04 in that cycle and 8'hA5 after the edge.
  - With REGFILE_BYPASS_EN: dout_a=8'hA5 in that cycle.
- Clear sequence: fill with 8'hFF, pulse clr_req.
  - busy is high for exactly 8 cycles; clr_done pulses in cycle 9.
  - All registers then read 8'h00.
  - A write of 8'h11 to addr 2 issued mid-clear is dropped (reads 8'h00 afterwards).
- Mid-clear abort: assert rst 3 cycles into CLEAR -> busy drops asynchronously, no clr_done pulse, all registers read RESET_VAL.
- Non-power-of-two depth: DEPTH=5, write 8'h55 to addr 6 -> dropped; raddr=6 returns 0; addr 4 still writable and readable.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// Package     : regfile_pkg
// Description : Shared FSM encoding and address range helper for regfile_np.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_np_mux_n.sv
// ============================================================================
// Module      : mux_n
// Description : DEPTH-way mux over a flat bus; out-of-range selects yield 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_n
    import regfile_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic [SEL_W-1:0]       sel_i,
    input  logic [DEPTH*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]       dout_o
);

    always_comb begin
        dout_o = '0;
        if (addr_in_range(32'(sel_i), DEPTH)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel_i == SEL_W'(i)) begin
                    dout_o = data_i[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_np.sv
// ============================================================================
// Module      : regfile_np
// Description : DEPTH x WIDTH register file, 1 write / 2 combinational read
//               ports, with a one-register-per-cycle clear sequencer.
//               Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_np
    import regfile_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 8,
    parameter int              ADDR_W    = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  dout_a,
    output logic [WIDTH-1:0]  dout_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        ptr_q, ptr_d;
    logic                     busy_q, busy_d;
    logic                     clr_done_q, clr_done_d;
    logic [WIDTH-1:0]         regs_q [DEPTH];
    logic [DEPTH*WIDTH-1:0]   regs_flat;
    logic [WIDTH-1:0]         mux_a, mux_b;
    logic                     wr_en;

    assign wr_en = we && !busy_q && addr_in_range(32'(waddr), DEPTH);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d     = (state_d == ST_CLEAR);
        clr_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Clear has priority; a write in the IDLE cycle that starts a clear still lands first.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_q[i] <= RESET_VAL;
            end else if (state_q == ST_CLEAR && ptr_q == ADDR_W'(i)) begin
                regs_q[i] <= RESET_VAL;
            end else if (wr_en && waddr == ADDR_W'(i)) begin
                regs_q[i] <= wdata;
            end
        end
        assign regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end

    mux_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(ADDR_W)) u_mux_a (
        .sel_i  (raddr_a),
        .data_i (regs_flat),
        .dout_o (mux_a)
    );

    mux_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(ADDR_W)) u_mux_b (
        .sel_i  (raddr_b),
        .data_i (regs_flat),
        .dout_o (mux_b)
    );

`ifdef REGFILE_BYPASS_EN
    assign dout_a = (wr_en && waddr == raddr_a) ? wdata : mux_a;
    assign dout_b = (wr_en && waddr == raddr_b) ? wdata : mux_b;
`else
    assign dout_a = mux_a;
    assign dout_b = mux_b;
`endif

    assign busy     = busy_q;
    assign clr_done = clr_done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_np.sv
// ============================================================================
// Module      : tb_regfile_np
// Description : Self-checking bench for regfile_np (8-deep and 5-deep copies).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_np;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       we, clr_req, busy, clr_done;
    logic [2:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata, dout_a, dout_b;

    logic       f_we, f_clr_req, f_busy, f_clr_done;
    logic [2:0] f_waddr, f_raddr_a, f_raddr_b;
    logic [7:0] f_wdata, f_dout_a, f_dout_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mdl  [8];
    logic [7:0] mdl5 [5];

    regfile_np #(.WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .dout_a(dout_a), .dout_b(dout_b),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
    );

    regfile_np #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .we(f_we), .waddr(f_waddr), .wdata(f_wdata),
        .raddr_a(f_raddr_a), .raddr_b(f_raddr_b), .dout_a(f_dout_a), .dout_b(f_dout_b),
        .clr_req(f_clr_req), .busy(f_busy), .clr_done(f_clr_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        we = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0; clr_req = 0;
        f_we = 0; f_waddr = 0; f_wdata = 0; f_raddr_a = 0; f_raddr_b = 0; f_clr_req = 0;
        #3;
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        for (int i = 0; i < 5; i++) mdl5[i] = 8'h00;
        for (int a = 0; a < 8; a++) begin
            raddr_a = 3'(a);
            raddr_b = 3'(7 - a);
            #1;
            n_vec++;
            if (dout_a !== 8'h00) begin n_err++; $display("FAIL reset_dout_a addr %0d: got %h expected 00", a, dout_a); end
            n_vec++;
            if (dout_b !== 8'h00) begin n_err++; $display("FAIL reset_dout_b addr %0d: got %h expected 00", 7 - a, dout_b); end
        end
        n_vec++;
        if (busy !== 1'b0 || clr_done !== 1'b0) begin
            n_err++; $display("FAIL reset_status: got busy=%b clr_done=%b expected 0/0", busy, clr_done);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_dual_read();
        for (int i = 0; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = 8'(i + 1);
            tick();
            mdl[i] = 8'(i + 1);
        end
        we = 0;
        for (int a = 0; a < 8; a++) begin
            raddr_a = 3'(a);
            raddr_b = 3'(7 - a);
            #1;
            n_vec++;
            if (dout_a !== 8'(a + 1)) begin n_err++; $display("FAIL dual_read_a addr %0d: got %h expected %h", a, dout_a, 8'(a + 1)); end
            n_vec++;
            if (dout_b !== 8'(8 - a)) begin n_err++; $display("FAIL dual_read_b addr %0d: got %h expected %h", 7 - a, dout_b, 8'(8 - a)); end
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] exp_v;
        raddr_a = 3'd3;
        we = 1; waddr = 3'd3; wdata = 8'hA5;
        #1;
        exp_v = BYP ? 8'hA5 : mdl[3];
        n_vec++;
        if (dout_a !== exp_v) begin n_err++; $display("FAIL same_cycle_pre: got %h expected %h", dout_a, exp_v); end
        tick();
        mdl[3] = 8'hA5;
        we = 0;
        #1;
        n_vec++;
        if (dout_a !== 8'hA5) begin n_err++; $display("FAIL same_cycle_post: got %h expected a5", dout_a); end
    endtask

    task automatic test_random();
        logic [7:0] ea, eb;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            waddr = 3'($urandom);
            wdata = 8'($urandom);
            raddr_a = 3'($urandom);
            raddr_b = (n % 4 == 0) ? raddr_a : 3'($urandom);
            #1;
            ea = (BYP && we && waddr == raddr_a) ? wdata : mdl[raddr_a];
            eb = (BYP && we && waddr == raddr_b) ? wdata : mdl[raddr_b];
            n_vec++;
            if (dout_a !== ea) begin n_err++; $display("FAIL random_a iter %0d: got %h expected %h", n, dout_a, ea); end
            n_vec++;
            if (dout_b !== eb) begin n_err++; $display("FAIL random_b iter %0d: got %h expected %h", n, dout_b, eb); end
            tick();
            if (we) mdl[waddr] = wdata;
        end
        we = 0;
    endtask

    task automatic test_clear();
        int busy_cnt, done_cnt;
        logic [7:0] ea, eb;
        for (int i = 0; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = 8'hFF;
            tick();
            mdl[i] = 8'hFF;
        end
        we = 0;
        clr_req = 1;
        tick();
        clr_req = 0;
        busy_cnt = 0;
        done_cnt = 0;
        // Cycle k: k clearing edges have passed, so entries 0..k-1 already read zero.
        for (int k = 0; k < 12; k++) begin
            we = (k == 5); waddr = 3'd2; wdata = 8'h11;
            clr_req = (k == 4 || k == 8);
            raddr_a = 3'($urandom);
            raddr_b = 3'd2;
            #1;
            ea = (int'(raddr_a) < k) ? 8'h00 : 8'hFF;
            eb = (2 < k) ? 8'h00 : 8'hFF;
            if (busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) done_cnt++;
            n_vec++;
            if (busy !== (k < 8)) begin n_err++; $display("FAIL clear_busy cycle %0d: got %b expected %b", k, busy, (k < 8)); end
            n_vec++;
            if (clr_done !== (k == 8)) begin n_err++; $display("FAIL clear_done cycle %0d: got %b expected %b", k, clr_done, (k == 8)); end
            n_vec++;
            if (dout_a !== ea) begin n_err++; $display("FAIL clear_read_a cycle %0d addr %0d: got %h expected %h", k, raddr_a, dout_a, ea); end
            n_vec++;
            if (dout_b !== eb) begin n_err++; $display("FAIL clear_read_b cycle %0d: got %h expected %h", k, dout_b, eb); end
            tick();
        end
        we = 0; clr_req = 0;
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        n_vec++;
        if (busy_cnt != 8) begin n_err++; $display("FAIL clear_busy_len: got %0d expected 8", busy_cnt); end
        n_vec++;
        if (done_cnt != 1) begin n_err++; $display("FAIL clear_done_pulses: got %0d expected 1", done_cnt); end
        for (int a = 0; a < 8; a++) begin
            raddr_a = 3'(a);
            #1;
            n_vec++;
            if (dout_a !== 8'h00) begin n_err++; $display("FAIL clear_final addr %0d: got %h expected 00", a, dout_a); end
        end
    endtask

    task automatic test_we_and_clr();
        bit seen;
        raddr_a = 3'd1;
        we = 1; waddr = 3'd1; wdata = 8'h77; clr_req = 1;
        tick();
        we = 0; clr_req = 0;
        n_vec++;
        if (dout_a !== 8'h77) begin n_err++; $display("FAIL we_clr_commit: got %h expected 77", dout_a); end
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL we_clr_busy: got %b expected 1", busy); end
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (clr_done === 1'b1) seen = 1;
            else tick();
        end
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL we_clr_timeout: got no clr_done expected pulse within 20 cycles"); end
        n_vec++;
        if (dout_a !== 8'h00) begin n_err++; $display("FAIL we_clr_overwrite: got %h expected 00", dout_a); end
        tick();
        mdl[1] = 8'h00;
    endtask

    task automatic test_abort();
        for (int i = 0; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = 8'($urandom_range(1, 255));
            tick();
            mdl[i] = wdata;
        end
        we = 0;
        clr_req = 1;
        tick();
        clr_req = 0;
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_async: got %b expected 0", busy); end
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        for (int i = 0; i < 5; i++) mdl5[i] = 8'h00;
        for (int a = 0; a < 8; a++) begin
            raddr_a = 3'(a);
            #0.1;
            n_vec++;
            if (dout_a !== 8'h00) begin n_err++; $display("FAIL abort_read addr %0d: got %h expected 00", a, dout_a); end
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_vec++;
            if (busy !== 1'b0 || clr_done !== 1'b0) begin
                n_err++; $display("FAIL abort_quiet cycle %0d: got busy=%b clr_done=%b expected 0/0", c, busy, clr_done);
            end
        end
    endtask

    task automatic test_depth5();
        logic [7:0] ea, eb;
        f_we = 1; f_waddr = 3'd6; f_wdata = 8'h55; f_raddr_a = 3'd6;
        #1;
        n_vec++;
        if (f_dout_a !== 8'h00) begin n_err++; $display("FAIL d5_oob_same_cycle: got %h expected 00", f_dout_a); end
        tick();
        f_we = 0;
        n_vec++;
        if (f_dout_a !== 8'h00) begin n_err++; $display("FAIL d5_oob_read: got %h expected 00", f_dout_a); end
        for (int a = 0; a < 5; a++) begin
            f_raddr_b = 3'(a);
            #1;
            n_vec++;
            if (f_dout_b !== mdl5[a]) begin n_err++; $display("FAIL d5_untouched addr %0d: got %h expected %h", a, f_dout_b, mdl5[a]); end
        end
        f_we = 1; f_waddr = 3'd4; f_wdata = 8'h3C; f_raddr_a = 3'd4;
        tick();
        mdl5[4] = 8'h3C;
        f_we = 0;
        n_vec++;
        if (f_dout_a !== 8'h3C) begin n_err++; $display("FAIL d5_last_addr: got %h expected 3c", f_dout_a); end
        for (int n = 0; n < 150; n++) begin
            f_we = 1'($urandom);
            f_waddr = 3'($urandom);
            f_wdata = 8'($urandom);
            f_raddr_a = 3'($urandom);
            f_raddr_b = 3'($urandom);
            #1;
            ea = (f_raddr_a >= 5) ? 8'h00 :
                 (BYP && f_we && f_waddr == f_raddr_a) ? f_wdata : mdl5[f_raddr_a];
            eb = (f_raddr_b >= 5) ? 8'h00 :
                 (BYP && f_we && f_waddr == f_raddr_b) ? f_wdata : mdl5[f_raddr_b];
            n_vec++;
            if (f_dout_a !== ea) begin n_err++; $display("FAIL d5_random_a iter %0d: got %h expected %h", n, f_dout_a, ea); end
            n_vec++;
            if (f_dout_b !== eb) begin n_err++; $display("FAIL d5_random_b iter %0d: got %h expected %h", n, f_dout_b, eb); end
            tick();
            if (f_we && f_waddr < 5) mdl5[f_waddr] = f_wdata;
        end
        f_we = 0;
    endtask

    initial begin
        test_reset();
        test_write_dual_read();
        test_same_cycle();
        test_random();
        test_clear();
        test_we_and_clr();
        test_abort();
        test_depth5();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
